// File: rtl/alu_pkg.sv
// Purpose : shared encodings and constants for the iterative multiply/divide unit.
// Latency : n/a (types and constants only).
// Backpr. : n/a.
// Contents: md_op_e operation codes, md_state_e FSM states, MD_ITER loop length.
package alu_pkg;

  // One radix-2 iteration per operand bit.
  localparam int MD_ITER = 32;

  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } md_op_e;

  typedef enum logic [2:0] {
    MD_IDLE = 3'd0,
    MD_PREP = 3'd1,
    MD_CALC = 3'd2,
    MD_FIX  = 3'd3,
    MD_DONE = 3'd4
  } md_state_e;

  function automatic logic md_is_div(input md_op_e op);
    return op inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU};
  endfunction

endpackage

// File: rtl/alu_muldiv_step.sv
// Purpose : one radix-2 iteration: shift-add multiply step or restoring-divide step.
// Latency : combinational.
// Backpr. : none; evaluated every cycle, the caller decides when to register it.
// Ports   : is_div_i selects divide; hi_i/lo_i are the accumulator halves (product
//           or remainder/quotient), opnd_i the multiplicand or divisor; hi_o/lo_o next halves.
module alu_muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             is_div_i,
  input  logic [WIDTH-1:0] hi_i,
  input  logic [WIDTH-1:0] lo_i,
  input  logic [WIDTH-1:0] opnd_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  logic [WIDTH:0] x;
  logic [WIDTH:0] y;
  logic [WIDTH:0] sum;
  logic           ge;

  always_comb begin
    x    = '0;
    y    = '0;
    sum  = '0;
    ge   = 1'b0;
    hi_o = hi_i;
    lo_o = lo_i;
    if (is_div_i) begin
      // Remainder shifted left with the next dividend bit; one shared adder
      // does the trial subtraction as x + ~y + 1.
      x   = {hi_i, lo_i[WIDTH-1]};
      y   = ~{1'b0, opnd_i};
      sum = x + y + (WIDTH+1)'(1);
      // The remainder is always below the divisor, so the true difference
      // fits in WIDTH bits whenever it is non-negative; bit WIDTH is the borrow.
      ge   = ~sum[WIDTH];
      hi_o = ge ? sum[WIDTH-1:0] : x[WIDTH-1:0];
      lo_o = {lo_i[WIDTH-2:0], ge};
    end else begin
      // Multiplier sits in lo and drains out of bit 0 as the product shifts in.
      x    = {1'b0, hi_i};
      y    = lo_i[0] ? {1'b0, opnd_i} : '0;
      sum  = x + y;
      hi_o = sum[WIDTH:1];
      lo_o = {sum[0], lo_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/alu_muldiv.sv
// Purpose : iterative 32-bit multiply/divide feeding one input of the ALU result mux.
// Latency : fixed 35 cycles accept-to-ready; done pulses 34 cycles after accept.
// Backpr. : ready low while busy; start ignored when not ready; flush aborts to IDLE.
// Ports   : clk, rst_n (async active-low); start/op/a/b request, ready accept-able;
//           flush synchronous abort; done one-cycle pulse; result held until next completion.
module alu_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH);

  md_state_e        state_q;
  logic [CW-1:0]    cnt_q;
  md_op_e           op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] opnd_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             neg_q;      // negate product / quotient
  logic             neg_rem_q;  // negate remainder (follows dividend sign)
  logic             ready_q;
  logic             done_q;
  logic [WIDTH-1:0] result_q;

  logic [WIDTH-1:0] hi_d;
  logic [WIDTH-1:0] lo_d;
  logic [WIDTH-1:0] result_d;

  logic             is_div;
  logic             sign_a;
  logic             sign_b;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;

  assign is_div = md_is_div(op_q);

  // MUL only needs the low word, which is sign-agnostic, so it runs unsigned.
  assign sign_a = a_q[WIDTH-1] & (op_q inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM});
  assign sign_b = b_q[WIDTH-1] & (op_q inside {MD_MULH, MD_DIV, MD_REM});
  assign abs_a  = sign_a ? -a_q : a_q;
  assign abs_b  = sign_b ? -b_q : b_q;

  alu_muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div_i (is_div),
    .hi_i     (hi_q),
    .lo_i     (lo_q),
    .opnd_i   (opnd_q),
    .hi_o     (hi_d),
    .lo_o     (lo_d)
  );

  // Sign fix-up and output selection. Signed overflow needs no special case:
  // |0x80000000| / 1 = 0x80000000, whose negation is itself, remainder 0.
  always_comb begin
    prod_fix = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
    quo_fix  = neg_q ? -lo_q : lo_q;
    rem_fix  = neg_rem_q ? -hi_q : hi_q;
    result_d = '0;
    case (op_q)
      MD_MUL:                      result_d = prod_fix[WIDTH-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: result_d = prod_fix[2*WIDTH-1:WIDTH];
      MD_DIV, MD_DIVU:             result_d = (b_q == '0) ? '1  : quo_fix;
      MD_REM, MD_REMU:             result_d = (b_q == '0) ? a_q : rem_fix;
      default:                     result_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= MD_IDLE;
      cnt_q     <= '0;
      op_q      <= MD_MUL;
      a_q       <= '0;
      b_q       <= '0;
      opnd_q    <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
      result_q  <= '0;
    end else if (flush) begin
      // Abort wins over everything, including a same-cycle start.
      state_q <= MD_IDLE;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        MD_IDLE: begin
          if (start && ready_q) begin
            op_q    <= md_op_e'(op);
            a_q     <= a;
            b_q     <= b;
            ready_q <= 1'b0;
            state_q <= MD_PREP;
          end
        end
        MD_PREP: begin
          hi_q      <= '0;
          lo_q      <= is_div ? abs_a : abs_b;
          opnd_q    <= is_div ? abs_b : abs_a;
          neg_q     <= sign_a ^ sign_b;
          neg_rem_q <= sign_a;
          cnt_q     <= '0;
          state_q   <= MD_CALC;
        end
        MD_CALC: begin
          hi_q  <= hi_d;
          lo_q  <= lo_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_q <= MD_FIX;
          end
        end
        MD_FIX: begin
          result_q <= result_d;
          done_q   <= 1'b1;
          state_q  <= MD_DONE;
        end
        MD_DONE: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= MD_IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= MD_IDLE;
        end
      endcase
    end
  end

  assign ready  = ready_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// Purpose : self-checking bench for alu_muldiv against an arithmetic reference model.
// Latency : checks done at accept+34 and ready back after accept+35.
// Backpr. : drives start only on cycles where ready is expected high.
module tb_alu_muldiv;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        ready;
  logic        done;
  logic [31:0] result;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] exp_result = '0;

  always #5 clk = ~clk;

  alu_muldiv #(.WIDTH(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .flush  (flush),
    .ready  (ready),
    .done   (done),
    .result (result)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic on sign/zero-extended operands.
  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [63:0]        sx;
    logic [63:0]        sy;
    logic [63:0]        zx;
    logic [63:0]        zy;
    logic [63:0]        p;
    logic signed [31:0] xs;
    logic signed [31:0] ys;
    logic               ovf;
    sx  = {{32{x[31]}}, x};
    sy  = {{32{y[31]}}, y};
    zx  = {32'b0, x};
    zy  = {32'b0, y};
    xs  = x;
    ys  = y;
    ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
    case (o)
      3'd0: begin p = zx * zy; return p[31:0]; end
      3'd1: begin p = sx * sy; return p[63:32]; end
      3'd2: begin p = sx * zy; return p[63:32]; end
      3'd3: begin p = zx * zy; return p[63:32]; end
      3'd4: return (y == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(xs / ys);
      3'd5: return (y == 0) ? 32'hFFFF_FFFF : x / y;
      3'd6: return (y == 0) ? x : ovf ? 32'h0 : 32'(xs % ys);
      default: return (y == 0) ? x : x % y;
    endcase
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 20));
      4:       return -32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  // Called positioned just after a negedge. Accepts at the next posedge (E0)
  // and tracks 36 intervals (after E0..E35). busy_at/flush_at name the edge
  // at which a stray start / a flush is presented (-1 = none).
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] want,
                        input int busy_at, input int flush_at);
    int          done_cyc = -1;
    int          done_cnt = 0;
    int          rdy_err  = 0;
    int          res_err  = 0;
    logic        exp_rdy;
    logic [31:0] exp_res;
    logic [31:0] prev;
    prev = exp_result;
    check({tag, " ready_before_accept"}, ready, 1);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; op = ~o; a = $urandom; b = $urandom;
    for (int n = 0; n <= 35; n++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = n;
      end
      exp_rdy = (flush_at >= 0) ? (n >= flush_at) : (n >= 35);
      if (ready !== exp_rdy) rdy_err++;
      exp_res = (flush_at < 0 && n >= 34) ? want : prev;
      if (result !== exp_res) res_err++;
      start = (n + 1 == busy_at);
      if (start) begin
        op = 3'($urandom_range(0, 7)); a = $urandom; b = $urandom;
      end
      flush = (n + 1 == flush_at);
    end
    start = 1'b0;
    flush = 1'b0;
    if (flush_at < 0) begin
      check({tag, " done_cycle"}, done_cyc, 34);
      check({tag, " done_count"}, done_cnt, 1);
      exp_result = want;
    end else begin
      check({tag, " no_done_after_flush"}, done_cnt, 0);
    end
    check({tag, " ready_profile_errs"}, rdy_err, 0);
    check({tag, " result_track_errs"}, res_err, 0);
    check({tag, " result"}, result, exp_result);
  endtask

  initial begin
    logic [2:0]  ro;
    logic [31:0] ra;
    logic [31:0] rb;
    int          dcnt;

    rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    check("reset ready", ready, 1);
    check("reset done", done, 0);
    check("reset result", result, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vectors with hand-computed expectations, run back to back.
    run_op("mul 7*6",       MD_MUL,    32'd7,          32'd6,          32'h0000_002A, -1, -1);
    run_op("mulh -1*2",     MD_MULH,   32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFF, -1, -1);
    run_op("mulhu",         MD_MULHU,  32'hFFFF_FFFF,  32'd2,          32'h0000_0001, -1, -1);
    run_op("mulhsu",        MD_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFF, -1, -1);
    run_op("div -7/2",      MD_DIV,    32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD, -1, -1);
    run_op("rem -7/2",      MD_REM,    32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF, -1, -1);
    run_op("divu 100/7",    MD_DIVU,   32'd100,        32'd7,          32'd14,        -1, -1);
    run_op("remu 100/7",    MD_REMU,   32'd100,        32'd7,          32'd2,         -1, -1);
    run_op("div by zero",   MD_DIV,    32'd5,          32'd0,          32'hFFFF_FFFF, -1, -1);
    run_op("rem by zero",   MD_REM,    32'd5,          32'd0,          32'd5,         -1, -1);
    run_op("div overflow",  MD_DIV,    32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000, -1, -1);
    run_op("rem overflow",  MD_REM,    32'h8000_0000,  32'hFFFF_FFFF,  32'h0,         -1, -1);

    // Stray start at E10 must be ignored; flush at E20 aborts without done.
    run_op("busy start", MD_MULHU, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0B00_EA4E, 10, -1);
    run_op("flush",      MD_DIVU,  32'd1000,      32'd3,         32'd333,       -1, 20);

    // Randomized operations against the reference model.
    for (int i = 0; i < 30; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = pick_operand();
      rb = pick_operand();
      run_op($sformatf("rand%0d op%0d", i, ro), ro, ra, rb, model(ro, ra, rb), -1, -1);
    end

    // Asynchronous reset in the middle of CALC.
    op = MD_MUL; a = 32'd3; b = 32'd5; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (15) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async rst ready", ready, 1);
    check("async rst done", done, 0);
    check("async rst result", result, 0);
    exp_result = '0;
    @(negedge clk);
    rst_n = 1'b1;
    dcnt = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (done === 1'b1) dcnt++;
    end
    check("no done after async rst", dcnt, 0);
    check("result after async rst", result, 0);

    run_op("post reset mul", MD_MUL, 32'hFFFF_FFFD, 32'd4, 32'hFFFF_FFF4, -1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_muldiv.md
# alu_muldiv

Iterative 32-bit multiply/divide unit in the ALU, directly upstream of the ALU's 8-way 32-bit result mux; its `result` drives one mux input. It accepts one operation per start handshake and computes it with a radix-2 shift-add / restoring-divide loop over 32 iterations. It then holds the result stable until the next accepted operation.

## Interface
Parameters:
- `WIDTH`, 32: operand/result width; the iteration count equals `WIDTH`; only 32 is verified.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: request; accepted when `start && ready` at a rising edge.
- `op` input 3: operation, sampled on accept.
  - 0 MUL: low 32 bits of the product.
  - 1 MULH: signed×signed high 32 bits.
  - 2 MULHSU: signed×unsigned high 32 bits.
  - 3 MULHU: unsigned high 32 bits.
  - 4 DIV, 5 DIVU: quotient, signed / unsigned.
  - 6 REM, 7 REMU: remainder, signed / unsigned.
- `a` input 32: operand A / dividend, sampled on accept.
- `b` input 32: operand B / divisor, sampled on accept.
- `flush` input 1: synchronous abort; highest priority.
- `ready` output 1: unit in IDLE and able to accept.
- `done` output 1: one-cycle pulse; `result` is valid from this cycle onward.
- `result` output 32: registered result, held until the next completion.

## Operation
- FSM states: IDLE → PREP → CALC → FIX → DONE → IDLE.
  - IDLE: `ready`=1. On accept, latch `op`, `a` and `b`, then go to PREP.
  - PREP: record the signs required by `op`, take absolute values of the signed operands, clear the accumulator, set the counter to 0, then go to CALC.
  - CALC: one iteration per cycle. Multiply: conditional add and shift right over a 64-bit product. Divide: shift the remainder left, trial-subtract with a 33-bit subtractor, set the quotient bit. When the counter reaches 31, go to FIX.
  - FIX: negate the product, quotient or remainder as the signs require. Remainder takes the dividend's sign. Select the output half or word per `op`, then go to DONE.
  - DONE: `result` is registered and `done`=1. Go to IDLE.
- Special cases are resolved in FIX. The loop still runs its full length, so latency is fixed.
  - Divide by zero: quotient is 0xFFFFFFFF for DIV and DIVU; remainder is `a` for REM and REMU.
  - Signed overflow (0x80000000 / 0xFFFFFFFF): quotient is 0x80000000 and remainder is 0.
- `start` is ignored when `ready`=0; there is no queueing.
- `flush`:
  - In any state, the FSM goes to IDLE on the next edge and `done` stays 0.
  - `result` keeps its previous value.
  - If `flush` and `start` are both high while in IDLE, the start is dropped.

## Timing
- Reset values: state IDLE, `ready`=1, `done`=0, `result`=0, counter 0, internal registers 0.
- `rst_n` asserted mid-operation returns the unit to IDLE immediately (asynchronous); no `done` is produced.
- Cycle schedule, with accept at edge E0:
  - PREP from E0 to E1.
  - CALC from E1 to E33 (32 cycles).
  - FIX from E33 to E34.
  - `done`=1 and the new `result` from E34 to E35.
  - `ready` returns to 1 after E35.
- `ready` is low from E0 to E35 inclusive, so one operation takes 35 cycles.
- The earliest next accept is at E35 + 1 cycle, i.e. at the first edge where `ready` is sampled 1.
- `result` changes only at the E34 edge of a completing operation.

## Structure
- Shared package `alu_pkg` holds:
  - the `op` encodings `MD_MUL` … `MD_REMU`;
  - the state enum `MD_IDLE`, `MD_PREP`, `MD_CALC`, `MD_FIX`, `MD_DONE`;
  - the constant `MD_ITER = 32`.
- One sub-module, `alu_muldiv_step`: a combinational single-iteration datapath (33-bit add/subtract plus the shift mux), selected by a mul/div flag.
- The FSM, counter and sign fix-up stay in `alu_muldiv`.

## Test plan
- Reset, then MUL with a=7, b=6: `done` at E34 with `result`=0x2A; `ready` returns after E35.
- MULH with a=0xFFFFFFFF, b=2 gives 0xFFFFFFFF. MULHU with the same operands gives 0x00000001. MULHSU with a=0xFFFFFFFF, b=0xFFFFFFFF gives 0xFFFFFFFF.
- DIV with a=-7 (0xFFFFFFF9), b=2 gives 0xFFFFFFFD. REM with the same operands gives 0xFFFFFFFF. DIVU with a=100, b=7 gives 14. REMU with a=100, b=7 gives 2.
- Divide by zero: DIV with a=5, b=0 gives 0xFFFFFFFF and REM gives 5. Overflow: DIV with a=0x80000000, b=0xFFFFFFFF gives 0x80000000 and REM gives 0.
- Handshake:
  - `start` pulsed at E10 while busy is ignored.
  - `flush` at E20 gives `ready`=1 at E21, no `done`, and `result` unchanged.
  - Back-to-back ops, each accepted at its first `ready` edge, each produce `done` exactly 34 cycles after their accept.
- `rst_n` dropped mid-CALC (asynchronous, between edges): outputs go to their reset values immediately, and no `done` follows.
